// File: rtl/dmx512_rx.sv
`default_nettype none
// ============================================================================
// Module      : dmx512_rx
// Description : DMX512 receiver. Synchronises the serial line, detects the
//               break, decodes 8N2 slots at 250 kbaud and emits per-slot
//               strobes plus an end-of-frame summary.
//               Optional feature macro: DMX512_RX_SC_FILTER_EN. When defined,
//               frames with a nonzero start code emit no slot or frame pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmx512_rx #(
    parameter int CLKS_PER_BIT   = 200,
    parameter int BREAK_MIN_CLKS = 4400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dmx_signal,
    output logic [9:0] slot_addr,
    output logic [7:0] slot_data,
    output logic       slot_valid,
    output logic [7:0] start_code,
    output logic       frame_done,
    output logic [9:0] frame_slots,
    output logic       framing_err
);

    localparam int C_TMR_W = $clog2(CLKS_PER_BIT + 1);
    localparam int C_LOW_W = $clog2(BREAK_MIN_CLKS + 1);

    localparam logic [C_TMR_W-1:0] C_HALF_LAST = C_TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_TMR_W-1:0] C_BIT_LAST  = C_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [C_LOW_W-1:0] C_LOW_MAX   = C_LOW_W'(BREAK_MIN_CLKS);
    localparam logic [C_LOW_W-1:0] C_LOW_HIT   = C_LOW_W'(BREAK_MIN_CLKS - 1);
    localparam logic [9:0]         C_LAST_SLOT = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BREAK     = 3'd1,
        S_MAB       = 3'd2,
        S_START_BIT = 3'd3,
        S_DATA      = 3'd4,
        S_STOP      = 3'd5,
        S_INTERSLOT = 3'd6
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_line_d;
    logic [C_LOW_W-1:0] r_low_cnt;
    state_t             r_state;
    logic [C_TMR_W-1:0] r_tmr;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_shift;
    logic [9:0]         r_index;

    logic w_line;
    logic w_fall;
    logic w_break_hit;
    logic w_sc_pass;

    assign w_line = r_sync2;
    assign w_fall = r_line_d & ~w_line;

    // The break fires exactly once per low stretch: on the clock the counter
    // would reach the threshold. Once saturated it no longer matches.
    assign w_break_hit = ~w_line && (r_low_cnt == C_LOW_HIT);

`ifdef DMX512_RX_SC_FILTER_EN
    // Only the null start code carries dimmer data; anything else is muted.
    assign w_sc_pass = (start_code == 8'h00);
`else
    assign w_sc_pass = 1'b1;
`endif

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= dmx_signal;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    // Saturating count of consecutive low samples, cleared by any high sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_low_cnt <= '0;
        end else if (w_line) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt != C_LOW_MAX) begin
            r_low_cnt <= r_low_cnt + 1'b1;
        end
    end

    // Frame/slot decoder with registered one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_index     <= '0;
            slot_addr   <= '0;
            slot_data   <= '0;
            slot_valid  <= 1'b0;
            start_code  <= '0;
            frame_done  <= 1'b0;
            frame_slots <= '0;
            framing_err <= 1'b0;
        end else begin
            slot_valid  <= 1'b0;
            frame_done  <= 1'b0;
            framing_err <= 1'b0;

            if (w_break_hit) begin
                // A break terminates whatever frame was in progress. A nonzero
                // index means a start code was seen, so the frame is reported
                // with the number of data slots that arrived before it.
                if ((r_index != 10'd0) && w_sc_pass) begin
                    frame_done  <= 1'b1;
                    frame_slots <= r_index - 10'd1;
                end
                r_index <= '0;
                r_state <= S_BREAK;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end

                    S_BREAK: begin
                        if (w_line) begin
                            r_index <= '0;
                            r_state <= S_MAB;
                        end
                    end

                    S_MAB, S_INTERSLOT: begin
                        if (w_fall) begin
                            r_tmr   <= '0;
                            r_state <= S_START_BIT;
                        end
                    end

                    S_START_BIT: begin
                        if (r_tmr == C_HALF_LAST) begin
                            r_tmr <= '0;
                            if (!w_line) begin
                                r_bit_idx <= '0;
                                r_state   <= S_DATA;
                            end else begin
                                framing_err <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (r_tmr == C_BIT_LAST) begin
                            r_tmr   <= '0;
                            r_shift <= {w_line, r_shift[7:1]};
                            if (r_bit_idx == 3'd7) begin
                                r_stop_idx <= 1'b0;
                                r_state    <= S_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end

                    S_STOP: begin
                        if (r_tmr == C_BIT_LAST) begin
                            r_tmr <= '0;
                            if (!w_line) begin
                                // Slot is dropped; index is kept so a later
                                // break still reports the slots already taken.
                                framing_err <= 1'b1;
                                r_state     <= S_IDLE;
                            end else if (!r_stop_idx) begin
                                r_stop_idx <= 1'b1;
                            end else if (r_index == 10'd0) begin
                                start_code <= r_shift;
                                r_index    <= 10'd1;
                                r_state    <= S_INTERSLOT;
                            end else begin
                                if (w_sc_pass) begin
                                    slot_valid <= 1'b1;
                                    slot_addr  <= r_index;
                                    slot_data  <= r_shift;
                                end
                                if (r_index == C_LAST_SLOT) begin
                                    // Full universe: close the frame here and
                                    // ignore anything until the next break.
                                    if (w_sc_pass) begin
                                        frame_done  <= 1'b1;
                                        frame_slots <= C_LAST_SLOT;
                                    end
                                    r_index <= '0;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_index <= r_index + 10'd1;
                                    r_state <= S_INTERSLOT;
                                end
                            end
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmx512_rx.md
DMX512_RX -- requirements
Module: dmx512_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 200, meaning clocks per 4 us DMX bit at 50 MHz.
REQ-002 SHALL have parameter BREAK_MIN_CLKS, default 4400, meaning minimum consecutive low clocks (88 us) recognised as a break.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dmx_signal  input  1  asynchronous serial DMX line (idle high, 250 kbaud, 8N2, LSB first).
REQ-006 SHALL have port slot_addr  output  10  data slot number of slot_data, 1..512.
REQ-007 SHALL have port slot_data  output  8  received slot byte.
REQ-008 SHALL have port slot_valid  output  1  one-cycle pulse qualifying slot_addr/slot_data.
REQ-009 SHALL have port start_code  output  8  slot-0 byte of the current frame, held until the next start code.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse marking end of a frame.
REQ-011 SHALL have port frame_slots  output  10  count of data slots in the finished frame, valid with frame_done and held.
REQ-012 SHALL have port framing_err  output  1  one-cycle pulse on a low stop bit or a failed start-bit check.

Function
REQ-013 SHALL pass dmx_signal through a 2-flop synchroniser; all decoding uses the synchronised line only.
REQ-014 SHALL count consecutive low clocks in every state; on reaching BREAK_MIN_CLKS it enters BREAK from any state (break override); the counter saturates and clears on a high sample.
REQ-015 SHALL implement states IDLE, BREAK, MAB, START_BIT, DATA, STOP, INTERSLOT; reset state IDLE.
REQ-016 IDLE: waits for break override only; all falling edges are ignored.
REQ-017 BREAK: waits for line high -> MAB; slot index cleared to 0.
REQ-018 MAB, INTERSLOT: on falling edge -> START_BIT with bit timer cleared.
REQ-019 START_BIT: samples at CLKS_PER_BIT/2; low -> DATA; high -> framing_err pulse, IDLE.
REQ-020 DATA: samples every CLKS_PER_BIT from the start-bit sample, 8 bits LSB first -> STOP.
REQ-021 STOP: samples two stop bits at CLKS_PER_BIT spacing; any low sample -> framing_err pulse, slot discarded, IDLE.
REQ-022 On valid second stop bit: index 0 updates start_code; index 1..512 drives slot_addr=index, slot_data, slot_valid on the next clock edge; index increments; -> INTERSLOT.
REQ-023 After slot 512: frame_done pulses with frame_slots=512 in the same cycle as slot_valid; -> IDLE (extra slots ignored).
REQ-024 Break override with index 1..511 (short frame) SHALL pulse frame_done with frame_slots=index-1... precisely, number of data slots received; index 0 gives no frame_done.
REQ-025 slot_addr/slot_data SHALL hold their last values between pulses.

Reset
REQ-026 rst SHALL asynchronously force IDLE, clear counters, synchroniser flops to 1, and all outputs to 0.
REQ-027 Reset mid-slot SHALL discard the partial slot; decoding resumes only after the next break.

Configuration
REQ-028 Macro DMX512_RX_SC_FILTER_EN defined: a frame with nonzero start code produces no slot_valid and no frame_done; start_code still updates.
REQ-029 Macro undefined: slots emitted regardless of start code value.

Verification
REQ-030 dmx512 TX output looped to dmx_signal, writes 0xFF to 510 and 512 -> slot_valid for 1..512, data 0xFF at 510 and 512, 0x00 elsewhere, frame_done with frame_slots=512.
REQ-031 Break 100 us, MAB 12 us, start code 0x00, slots 0x11,0x22,0x33, break -> slot_valid addr 1/2/3 with 0x11/0x22/0x33, frame_done frame_slots=3 at second break.
REQ-032 Slot 2 with low second stop bit -> framing_err pulse, no slot_valid addr 2, no further slots until next break.
REQ-033 Low pulse 80 us then idle high -> no BREAK entry, no output pulses.
REQ-034 Start code 0xCC, 2 slots -> start_code=0xCC; with DMX512_RX_SC_FILTER_EN no slot_valid, without it slot_valid addr 1 and 2.
REQ-035 rst asserted mid-DATA of slot 5 -> all outputs 0 within the cycle, next full frame decoded correctly from slot 1.
